// File: rtl/dsk_sector_buffer_if.sv
// rtl/dsk_sector_buffer_if.sv - user_io SD block-device channel between a sector buffer and user_io
interface dsk_sector_buffer_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
    );
endinterface

// File: rtl/dsk_sector_buffer.sv
// rtl/dsk_sector_buffer.sv - one-sector initiator and dual-port buffer for a user_io image slot
module dsk_sector_buffer #(
    parameter int TO_W = 24
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_lba,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [8:0]  buf_addr,
    input  logic [7:0]  buf_din,
    input  logic        buf_we,
    output logic [7:0]  buf_dout,
    dsk_sector_buffer_if.master sd
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_XFER,
        S_FIN
    } state_t;

    // Leaving REQ on this value makes the request last exactly 2^TO_W-1 cycles.
    localparam logic [TO_W-1:0] TMO_LAST     = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [9:0]      SECTOR_BYTES = 10'd512;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     lba;
    logic [31:0]     sectors;
    logic            mounted;
    logic            dir_wr;
    logic [9:0]      cnt;
    logic [9:0]      cnt_nxt;
    logic [TO_W-1:0] tmo;
    logic            range_bad;
    logic            tmo_fire;
    logic            sd_we;
    logic            core_we;
    logic [7:0]      mem [512];

    assign range_bad = !mounted || (lba >= sectors);
    assign tmo_fire  = (tmo == TMO_LAST);
    assign sd_we     = (state == S_XFER) && !dir_wr && sd.sd_buff_wr;
    assign core_we   = buf_we && !busy;
    assign cnt_nxt   = (sd_we && (cnt != SECTOR_BYTES)) ? cnt + 10'd1 : cnt;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= S_IDLE;
            lba     <= '0;
            dir_wr  <= 1'b0;
            cnt     <= '0;
            tmo     <= '0;
            err     <= 1'b0;
            mounted <= 1'b0;
            sectors <= '0;
        end else begin
            state <= state_nxt;
            if (img_mounted) begin
                sectors <= img_size[40:9];
                mounted <= |img_size;
            end
            case (state)
                S_IDLE: begin
                    if (req_wr || req_rd) begin
                        lba    <= req_lba;
                        dir_wr <= req_wr;
                        cnt    <= '0;
                        err    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    tmo <= '0;
                    if (range_bad) err <= 1'b1;
                end
                S_REQ: begin
                    tmo <= tmo + 1'b1;
                    if (!sd.sd_ack && tmo_fire) err <= 1'b1;
                end
                S_XFER: begin
                    cnt <= cnt_nxt;
                    if (!sd.sd_ack) err <= !dir_wr && (cnt_nxt != SECTOR_BYTES);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_FIN);
        sd.sd_rd  = 1'b0;
        sd.sd_wr  = 1'b0;
        sd.sd_lba = lba;
        case (state)
            S_IDLE:  if (req_wr || req_rd) state_nxt = S_CHECK;
            S_CHECK: state_nxt = range_bad ? S_FIN : S_REQ;
            S_REQ: begin
                sd.sd_rd = !dir_wr;
                sd.sd_wr = dir_wr;
                if (sd.sd_ack)     state_nxt = S_XFER;
                else if (tmo_fire) state_nxt = S_FIN;
            end
            S_XFER:  if (!sd.sd_ack) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Core and user_io never write together: core writes are gated by busy.
    always_ff @(posedge clk_sys) begin
        if (core_we) mem[buf_addr] <= buf_din;
        if (sd_we)   mem[sd.sd_buff_addr] <= sd.sd_buff_dout;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_dout       <= '0;
            sd.sd_buff_din <= '0;
        end else begin
            buf_dout       <= mem[buf_addr];
            sd.sd_buff_din <= mem[sd.sd_buff_addr];
        end
    end
endmodule

// File: tb/tb_dsk_sector_buffer.sv
// tb/tb_dsk_sector_buffer.sv - randomized model-checked bench for dsk_sector_buffer
module tb_dsk_sector_buffer;
    localparam int TO_W    = 4;
    localparam int TMO_CYC = (1 << TO_W) - 1;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        img_mounted;
    logic [63:0] img_size;
    logic        req_rd;
    logic        req_wr;
    logic [31:0] req_lba;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_din;
    logic        buf_we;
    logic [7:0]  buf_dout;

    dsk_sector_buffer_if sd_if ();

    dsk_sector_buffer #(.TO_W(TO_W)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_lba     (req_lba),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .buf_addr    (buf_addr),
        .buf_din     (buf_din),
        .buf_we      (buf_we),
        .buf_dout    (buf_dout),
        .sd          (sd_if)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction timestamps plus a byte array for the buffer.
    int          cyc;
    logic [7:0]  mem_m [512];
    bit          mval  [512];
    bit          m_mounted;
    logic [31:0] m_sectors;
    bit          active, m_bad, m_dir, m_err;
    logic [31:0] m_lba;
    int          t_acc, t_rel, t_done, m_cnt;
    bit          chk_en;
    bit          e_busy, e_done, e_rd, e_wr, e_err, e_dout_v, e_din_v;
    logic [31:0] e_lba;
    logic [7:0]  e_dout, e_din;

    initial begin : model
        int s, nn;
        bit busy_now, sd_we_m, e_req;
        cyc = 0; active = 0; chk_en = 0; m_mounted = 0; m_sectors = 0;
        m_bad = 0; m_dir = 0; m_err = 0; m_lba = 0; t_acc = 0; t_rel = -1; t_done = -1; m_cnt = 0;
        e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_err = 0; e_lba = 0;
        e_dout = 0; e_din = 0; e_dout_v = 0; e_din_v = 0;
        foreach (mval[i]) mval[i] = 0;
        forever begin
            @(posedge clk_sys);
            s  = cyc;
            nn = cyc + 1;
            if (reset) begin
                active = 0; m_mounted = 0; m_sectors = 0;
                foreach (mval[i]) mval[i] = 0;
                e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0;
                e_dout = 0; e_din = 0; e_dout_v = 1; e_din_v = 1;
                chk_en = 1;
            end else begin
                busy_now = e_busy;
                sd_we_m  = 0;
                e_dout   = mem_m[buf_addr];
                e_dout_v = mval[buf_addr];
                e_din    = mem_m[sd_if.sd_buff_addr];
                e_din_v  = mval[sd_if.sd_buff_addr];
                if (active && s == t_done) begin
                    active = 0;
                end else if (!active) begin
                    if (req_rd || req_wr) begin
                        active = 1; t_acc = s; m_dir = req_wr; m_lba = req_lba;
                        m_cnt = 0; m_err = 0; m_bad = 0; t_rel = -1; t_done = -1;
                    end
                end else if (s == t_acc + 1) begin
                    m_bad = !m_mounted || (m_lba >= m_sectors);
                    if (m_bad) begin t_done = s + 1; m_err = 1; end
                end else if (!m_bad && t_done < 0) begin
                    if (t_rel < 0) begin
                        if (sd_if.sd_ack) t_rel = s + 1;
                        else if (s == t_acc + 2 + TMO_CYC - 1) begin
                            t_rel = s + 1; t_done = s + 1; m_err = 1;
                        end
                    end else begin
                        if (!m_dir && sd_if.sd_buff_wr) begin
                            sd_we_m = 1;
                            if (m_cnt < 512) m_cnt++;
                        end
                        if (!sd_if.sd_ack) begin
                            t_done = s + 1;
                            m_err  = !m_dir && (m_cnt != 512);
                        end
                    end
                end
                if (buf_we && !busy_now) begin
                    mem_m[buf_addr] = buf_din; mval[buf_addr] = 1;
                end
                if (sd_we_m) begin
                    mem_m[sd_if.sd_buff_addr] = sd_if.sd_buff_dout; mval[sd_if.sd_buff_addr] = 1;
                end
                if (img_mounted) begin
                    m_sectors = img_size[40:9];
                    m_mounted = (img_size != 0);
                end
                e_req  = active && !m_bad && (nn >= t_acc + 2) && (t_rel < 0 || nn < t_rel);
                e_busy = active;
                e_done = active && (t_done == nn);
                e_rd   = e_req && !m_dir;
                e_wr   = e_req && m_dir;
                e_err  = m_err;
                e_lba  = m_lba;
            end
            cyc = cyc + 1;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk_sys);
            if (chk_en) begin
                check("busy", busy, e_busy);
                check("done", done, e_done);
                check("sd_rd", sd_if.sd_rd, e_rd);
                check("sd_wr", sd_if.sd_wr, e_wr);
                if (e_rd || e_wr) check("sd_lba", sd_if.sd_lba, e_lba);
                if (e_done) check("err", err, e_err);
                if (e_dout_v) check("buf_dout", buf_dout, e_dout);
                if (e_din_v) check("sd_buff_din", sd_if.sd_buff_din, e_din);
            end
        end
    end

    int rd_high = 0;
    initial begin : req_monitor
        forever begin
            @(posedge clk_sys);
            #1;
            if (sd_if.sd_rd) rd_high++;
        end
    end

    int r_delay  = 4;
    int r_nbytes = 512;
    bit r_noack  = 0;
    bit r_rand   = 0;
    bit r_chk80  = 0;

    initial begin : responder
        bit is_rd;
        int nb;
        sd_if.sd_ack = 0; sd_if.sd_buff_wr = 0; sd_if.sd_buff_addr = 0; sd_if.sd_buff_dout = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset && !r_noack && (sd_if.sd_rd || sd_if.sd_wr)) begin
                is_rd = sd_if.sd_rd;
                nb    = is_rd ? r_nbytes : 512;
                repeat (r_delay) @(negedge clk_sys);
                sd_if.sd_ack = 1;
                @(negedge clk_sys);
                for (int i = 0; i < nb; i++) begin
                    if (reset) break;
                    if ($urandom_range(0, 3) == 0) begin
                        sd_if.sd_buff_wr = 0;
                        @(negedge clk_sys);
                    end
                    sd_if.sd_buff_addr = 9'(i);
                    sd_if.sd_buff_dout = r_rand ? 8'($urandom) : (8'(i) ^ 8'hA5);
                    sd_if.sd_buff_wr   = is_rd;
                    @(negedge clk_sys);
                    if (!is_rd && r_chk80 && i == 128) check("sd_buff_din_at_80", sd_if.sd_buff_din, 8'h80);
                end
                sd_if.sd_buff_wr = 0;
                sd_if.sd_ack     = 0;
            end
        end
    end

    bit core_rand = 0;
    int rd_base   = 0;

    task automatic tick();
        @(negedge clk_sys);
        if (core_rand) begin
            buf_addr = 9'($urandom);
            buf_din  = 8'($urandom);
            buf_we   = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic core_quiet();
        core_rand = 0;
        buf_we    = 0;
    endtask

    task automatic mount(input logic [63:0] sz);
        tick();
        img_mounted = 1; img_size = sz;
        tick();
        img_mounted = 0;
    endtask

    // Returns at the negedge of cycle N+1, where N is the request cycle.
    task automatic req_start(input bit rd, input bit wr, input logic [31:0] lba);
        tick();
        req_rd = rd; req_wr = wr; req_lba = lba;
        rd_base = rd_high;
        tick();
        req_rd = 0; req_wr = 0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int k;
        k = 0;
        while (!done && k < limit) begin
            tick();
            k++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic range_err_case(input string name, input logic [31:0] lba);
        req_start(1, 0, lba);
        check({name, "_busy_n1"}, busy, 1'b1);
        check({name, "_done_n1"}, done, 1'b0);
        tick();
        check({name, "_done_n2"}, done, 1'b1);
        check({name, "_err"}, err, 1'b1);
        check({name, "_sd_rd_never"}, 32'(rd_high - rd_base), 0);
    endtask

    initial begin : stimulus
        reset = 1; img_mounted = 0; img_size = 0; req_rd = 0; req_wr = 0; req_lba = 0;
        buf_addr = 0; buf_din = 0; buf_we = 0;
        repeat (4) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_sd_rd", sd_if.sd_rd, 1'b0);
        check("rst_sd_lba", sd_if.sd_lba, 32'h0);
        check("rst_buf_dout", buf_dout, 8'h00);
        reset = 0;

        range_err_case("unmounted", 32'd0);

        mount(64'd1048576);
        r_delay = 10; r_rand = 0; r_nbytes = 512;
        core_rand = 1;
        req_start(1, 0, 32'd5);
        tick();
        check("rd_sd_rd_n2", sd_if.sd_rd, 1'b1);
        check("rd_sd_lba", sd_if.sd_lba, 32'd5);
        wait_done("rd_done", 3000);
        check("rd_err", err, 1'b0);
        core_quiet();
        tick();
        buf_addr = 9'h1FF;
        tick();
        check("rd_buf_1ff", buf_dout, 8'h5A);

        for (int a = 0; a < 512; a++) begin
            tick();
            buf_addr = 9'(a); buf_din = 8'(a); buf_we = 1;
        end
        tick();
        buf_we = 0;
        r_chk80 = 1; r_delay = 3;
        req_start(0, 1, 32'd2047);
        tick();
        check("wr_sd_wr_n2", sd_if.sd_wr, 1'b1);
        wait_done("wr_done", 3000);
        check("wr_err", err, 1'b0);
        r_chk80 = 0;

        range_err_case("lba_2048", 32'd2048);

        r_nbytes = 511; r_rand = 1;
        req_start(1, 0, 32'd17);
        wait_done("short_done", 3000);
        check("short_err", err, 1'b1);
        r_nbytes = 512;

        r_noack = 1;
        req_start(1, 0, 32'd3);
        wait_done("tmo_done", 100);
        check("tmo_rd_cycles", 32'(rd_high - rd_base), 32'(TMO_CYC));
        check("tmo_err", err, 1'b1);
        r_noack = 0;

        req_start(1, 1, 32'd10);
        tick();
        check("both_sd_wr", sd_if.sd_wr, 1'b1);
        check("both_sd_rd", sd_if.sd_rd, 1'b0);
        req_rd = 1; req_lba = 32'd77;
        tick();
        req_rd = 0;
        wait_done("both_done", 3000);
        check("both_err", err, 1'b0);

        r_delay = 2;
        req_start(1, 0, 32'd100);
        repeat (40) tick();
        check("mid_xfer_busy", busy, 1'b1);
        reset = 1;
        tick();
        check("rstx_sd_rd", sd_if.sd_rd, 1'b0);
        check("rstx_busy", busy, 1'b0);
        repeat (3) tick();
        reset = 0;

        mount(64'd1048576);
        for (int it = 0; it < 12; it++) begin
            bit dir;
            if (it == 6) mount(64'($urandom_range(0, 3)) * 64'd512 * 64'd700);
            core_rand = 1;
            repeat ($urandom_range(5, 40)) tick();
            r_delay  = $urandom_range(1, 12);
            r_nbytes = ($urandom_range(0, 5) == 0) ? 511 : 512;
            dir      = 1'($urandom_range(0, 1));
            req_start(!dir, dir, 32'($urandom_range(0, 2100)));
            wait_done("rand_done", 3000);
        end
        core_rand = 1;
        repeat (30) tick();
        core_quiet();
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
